// File: rtl/mcpu_pkg.sv
// Shared micro-CPU definitions: word/address widths, reset PC and the
// fetch entry record passed from fetch to decode.
package mcpu_pkg;

  localparam int MCPU_WORD_SIZE  = 8;
  localparam int MCPU_ADDR_WIDTH = 8;

  localparam logic [MCPU_ADDR_WIDTH-1:0] MCPU_RESET_PC = 8'h00;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [MCPU_ADDR_WIDTH-1:0] pc;
    logic [MCPU_WORD_SIZE-1:0]  word;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_ENTRY_NULL = '{
    pc:   {MCPU_ADDR_WIDTH{1'b0}},
    word: {MCPU_WORD_SIZE{1'b0}}
  };

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Saturating increment for 16-bit event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == STALL_MAX) begin
      result = STALL_MAX;
    end else begin
      result = value + 16'h0001;
    end
    return result;
  endfunction

endpackage

// File: rtl/mcpu_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t. Flush wins over push and discards any
// pop of the same cycle. The head is presented from storage registers and
// forced to zero while the FIFO is empty.
module mcpu_fetch_fifo
  import mcpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == CNT_DEPTH);

  // Qualify requests against occupancy; a pop frees the slot a full push needs.
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Entry storage; nothing is written in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= FETCH_ENTRY_NULL;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Pointer and occupancy bookkeeping with flush taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view: stored entry at the read pointer, zero while empty.
  always_comb begin
    if (empty) begin
      head = FETCH_ENTRY_NULL;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// Instruction fetch stage: walks a fetch PC over the RAM instruction port,
// captures the same-cycle word into a prefetch FIFO and hands entries to
// decode over valid/ready. Redirects flush the FIFO and reload the PC;
// halt stops new fetches while the FIFO keeps draining.
// Optional feature macro: MCPU_FETCH_PERF_EN adds the stall_cycles counter.
module mcpu_fetch_unit
  import mcpu_pkg::*;
#(
  parameter int                    WORD_SIZE  = MCPU_WORD_SIZE,
  parameter int                    ADDR_WIDTH = MCPU_ADDR_WIDTH,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = MCPU_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [WORD_SIZE-1:0]  instr_rd,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WORD_SIZE-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef MCPU_FETCH_PERF_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  fetch_entry_t          wr_entry_s;
  fetch_entry_t          head_s;

  assign instr_addr  = fetch_pc_r;
  assign instr_valid = ~empty_s;
  assign instr       = head_s.word;
  assign instr_pc    = head_s.pc;

  // Handshake and fetch decision; a redirect or halt suppresses the push.
  always_comb begin
    pop_s           = instr_valid & instr_ready;
    wr_entry_s.pc   = fetch_pc_r;
    wr_entry_s.word = instr_rd;
    if (halt || redirect_valid) begin
      push_s = 1'b0;
    end else begin
      push_s = ~full_s | pop_s;
    end
  end

  // Fetch PC: reload on redirect (even under halt), advance on each push, wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + PC_ONE;
    end
  end

  mcpu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s)
  );

`ifdef MCPU_FETCH_PERF_EN
  // Count cycles where decode is starved without a halt; saturating, reset-only clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'h0000;
    end else if (!instr_valid && !halt) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end
`endif

endmodule
